// File: rtl/piso_deb_ctrl_if.sv
// Debug byte port between piso_deb_ctrl and the debug-port consumer.
// The controller qualifies the byte piso_deb presents on D_OUT.
interface piso_deb_ctrl_if;
    logic       DEB_VALID;
    logic       DEB_READY;
    logic [3:0] DEB_IDX;
    logic       DEB_LAST;

    modport master (
        output DEB_VALID,
        output DEB_IDX,
        output DEB_LAST,
        input  DEB_READY
    );

    modport slave (
        input  DEB_VALID,
        input  DEB_IDX,
        input  DEB_LAST,
        output DEB_READY
    );
endinterface

// File: rtl/piso_deb_ctrl.sv
// Sequencer for the debug PISO: runs one snapshot dump (clear, capture,
// shift NBYTES bytes under valid/ready), triggered by a host strobe or by
// a periodic auto trigger. Host strobe and auto trigger in the same cycle
// start a single dump.
module piso_deb_ctrl #(
    parameter int NBYTES      = 12,
    parameter int AUTO_PERIOD = 0,
    parameter int TMR_W       = 16
) (
    input  logic            CLKEXT,
    input  logic            RST_GLO,
    input  logic            DBG_START,
    input  logic            DBG_ABORT,
    input  logic            AUTO_EN,
    piso_deb_ctrl_if.master deb,
    output logic            EN_PISO_DEB,
    output logic            CLR_PISO_DEB,
    output logic            SHIFT_DEB,
    output logic            DBG_BUSY,
    output logic            DBG_DONE,
    output logic            DBG_ABORTED
);

    localparam int              SW        = $clog2(NBYTES + 1);
    localparam logic [SW-1:0]   SENT_MAX  = SW'(NBYTES);
    localparam logic [SW-1:0]   SENT_LAST = SW'(NBYTES - 1);
    localparam logic [3:0]      IDX_LAST  = 4'(NBYTES - 1);
    localparam bit              AUTO_ON   = (AUTO_PERIOD != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = AUTO_ON ? TMR_W'(AUTO_PERIOD - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CAPTURE,
        S_SHIFT,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state;
    logic [SW-1:0]    sent;
    logic [TMR_W-1:0] timer;
    logic             pending;
    logic             tick;
    logic             trigger;
    logic             abort_hit;

    assign tick      = AUTO_ON && AUTO_EN && (timer == TMR_LAST);
    assign trigger   = DBG_START || pending || tick;
    assign abort_hit = DBG_ABORT && (state != S_IDLE) && (state != S_ABORT);

    // Shift request follows the downstream handshake combinationally so a
    // byte is only advanced when D_OUT is empty or being accepted; an abort
    // in the same cycle suppresses it so piso_deb never moves during abort.
    assign SHIFT_DEB = (state == S_SHIFT) && !DBG_ABORT && (sent < SENT_MAX) &&
                       (!deb.DEB_VALID || deb.DEB_READY);

    assign deb.DEB_LAST = deb.DEB_VALID && (deb.DEB_IDX == IDX_LAST);

    // Auto-trigger timer: free-runs while enabled, wraps after the last count.
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO || !AUTO_ON || !AUTO_EN) begin
            timer <= '0;
        end else if (timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Dump sequencer with registered piso_deb controls, handshake and pulses.
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            state         <= S_IDLE;
            sent          <= '0;
            pending       <= 1'b0;
            EN_PISO_DEB   <= 1'b0;
            CLR_PISO_DEB  <= 1'b0;
            DBG_BUSY      <= 1'b0;
            DBG_DONE      <= 1'b0;
            DBG_ABORTED   <= 1'b0;
            deb.DEB_VALID <= 1'b0;
            deb.DEB_IDX   <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block
            // deliberately override the defaults written at its top.
            CLR_PISO_DEB  <= 1'b0;
            DBG_DONE      <= 1'b0;
            DBG_ABORTED   <= 1'b0;
            deb.DEB_VALID <= SHIFT_DEB || (deb.DEB_VALID && !deb.DEB_READY);

            if (SHIFT_DEB) begin
                sent        <= sent + SW'(1);
                deb.DEB_IDX <= 4'(sent);
            end

            // A tick while busy is held as a single pending request.
            if (tick) begin
                pending <= 1'b1;
            end

            if (abort_hit) begin
                state         <= S_ABORT;
                CLR_PISO_DEB  <= 1'b1;
                EN_PISO_DEB   <= 1'b0;
                DBG_ABORTED   <= 1'b1;
                deb.DEB_VALID <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (trigger) begin
                            state         <= S_CLEAR;
                            CLR_PISO_DEB  <= 1'b1;
                            DBG_BUSY      <= 1'b1;
                            sent          <= '0;
                            pending       <= 1'b0;
                            deb.DEB_VALID <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        state       <= S_CAPTURE;
                        EN_PISO_DEB <= 1'b1;
                    end
                    S_CAPTURE: begin
                        state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (SHIFT_DEB && (sent == SENT_LAST)) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (deb.DEB_VALID && deb.DEB_READY) begin
                            state       <= S_DONE;
                            EN_PISO_DEB <= 1'b0;
                            DBG_DONE    <= 1'b1;
                        end
                    end
                    S_DONE, S_ABORT: begin
                        state    <= S_IDLE;
                        DBG_BUSY <= 1'b0;
                    end
                    default: begin
                        state       <= S_IDLE;
                        EN_PISO_DEB <= 1'b0;
                        DBG_BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
